// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the execute-stage multiply/divide sequencer.
// Op encodings match what the decoder emits.
package muldiv_ctrl_pkg;

   typedef enum logic [2:0] {
      mulop_none,
      mulop_mul,
      mulop_mulh,
      mulop_mulhsu,
      mulop_mulhu
   } rv32_mulop;

   typedef enum logic [2:0] {
      divop_none,
      divop_div,
      divop_divu,
      divop_rem,
      divop_remu
   } rv32_divop;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } muldiv_state;

   localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN       = 32'h8000_0000;

   function automatic logic is_signed_divop(input rv32_divop op);
      return (op == divop_div) || (op == divop_rem);
   endfunction

   function automatic logic is_quotient_divop(input rv32_divop op);
      return (op == divop_div) || (op == divop_divu);
   endfunction

endpackage

// File: rtl/muldiv_ctrl_div_special.sv
// Divide corner cases (divide-by-zero, signed overflow) resolved without the divider.
// Purely combinational; also shared with the divider core's own checks.
module div_special_case
   import muldiv_ctrl_pkg::*;
(
   input  rv32_divop   i_divop,
   input  logic [31:0] i_data_a,
   input  logic [31:0] i_data_b,
   output logic        o_special,
   output logic [31:0] o_result
);

   logic div_by_zero;
   logic overflow;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      div_by_zero = (i_divop != divop_none) && (i_data_b == '0);
      overflow    = is_signed_divop(i_divop) && (i_data_a == INT_MIN) && (i_data_b == '1);
      o_special   = div_by_zero || overflow;
      o_result    = '0;
      if (div_by_zero) begin
         o_result = is_quotient_divop(i_divop) ? DIV_BY_ZERO_Q : i_data_a;
      end else if (overflow) begin
         o_result = is_quotient_divop(i_divop) ? INT_MIN : '0;
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared multi-cycle multiply/divide unit beside the execute ALU:
// issues mul enable / div start-abort, stalls execute, and holds the result.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int MUL_LATENCY = 3
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_flush,
   input  logic        i_valid,
   input  logic        i_alu_en,
   input  logic        i_stall_down,
   input  rv32_mulop   i_mulop,
   input  rv32_divop   i_divop,
   input  logic [31:0] i_data_a,
   input  logic [31:0] i_data_b,
   input  logic [31:0] i_mul_result,
   input  logic        i_div_done,
   input  logic [31:0] i_div_result,
   output logic        o_mul_en,
   output logic        o_div_start,
   output logic        o_div_abort,
   output logic        o_stall,
   output logic [31:0] o_result,
   output logic        o_result_valid,
   output logic        o_busy
);

   localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LATENCY - 1);

   muldiv_state state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] result_q, result_d;
   logic        start_q, start_d;

   logic        is_mul;
   logic        is_div;
   logic        accept;
   logic        special;
   logic [31:0] special_result;

   div_special_case u_div_special (
      .i_divop   (i_divop),
      .i_data_a  (i_data_a),
      .i_data_b  (i_data_b),
      .o_special (special),
      .o_result  (special_result)
   );

   assign is_mul = (i_mulop != mulop_none);
   assign is_div = (i_divop != divop_none);

   // Gated by reset so every output reads 0 while reset is held.
   assign accept = !i_rst && (state_q == IDLE) && i_valid && i_alu_en && !i_flush
                   && (is_mul || is_div);

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      result_d       = result_q;
      start_d        = 1'b0;
      o_mul_en       = 1'b0;
      o_result_valid = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_div) begin
                  if (special) begin
                     result_d = special_result;
                     state_d  = DONE;
                  end else begin
                     start_d = 1'b1;
                     state_d = DIV;
                  end
               end else begin
                  cnt_d   = MUL_CNT_INIT;
                  state_d = MUL;
               end
            end
         end
         MUL: begin
            o_mul_en = 1'b1;
            if (cnt_q == '0) begin
               result_d = i_mul_result;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DIV: begin
            if (i_div_done) begin
               result_d = i_div_result;
               state_d  = DONE;
            end
         end
         DONE: begin
            o_result_valid = 1'b1;
            if (!i_stall_down) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A flush drops whatever is in flight, including a result arriving this cycle.
      if (i_flush) begin
         state_d  = IDLE;
         cnt_d    = cnt_q;
         result_d = result_q;
         start_d  = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         result_q <= '0;
         start_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         start_q  <= start_d;
      end
   end

   assign o_div_start = start_q;
   assign o_div_abort = i_flush && (state_q == DIV) && !i_div_done;
   assign o_stall     = !i_flush && (accept || (state_q == MUL) || (state_q == DIV));
   assign o_result    = result_q;
   assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: table of ops with a multiplier/divider responder
// and a result scoreboard, plus hand-written flush, hold and reset sequences.
module tb_muldiv_ctrl;
   import muldiv_ctrl_pkg::*;

   localparam int L = 3;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_flush;
   logic        i_valid;
   logic        i_alu_en;
   logic        i_stall_down;
   rv32_mulop   i_mulop;
   rv32_divop   i_divop;
   logic [31:0] i_data_a;
   logic [31:0] i_data_b;
   logic [31:0] i_mul_result;
   logic        i_div_done;
   logic [31:0] i_div_result;
   logic        o_mul_en;
   logic        o_div_start;
   logic        o_div_abort;
   logic        o_stall;
   logic [31:0] o_result;
   logic        o_result_valid;
   logic        o_busy;

   muldiv_ctrl #(.MUL_LATENCY(L)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_flush        (i_flush),
      .i_valid        (i_valid),
      .i_alu_en       (i_alu_en),
      .i_stall_down   (i_stall_down),
      .i_mulop        (i_mulop),
      .i_divop        (i_divop),
      .i_data_a       (i_data_a),
      .i_data_b       (i_data_b),
      .i_mul_result   (i_mul_result),
      .i_div_done     (i_div_done),
      .i_div_result   (i_div_result),
      .o_mul_en       (o_mul_en),
      .o_div_start    (o_div_start),
      .o_div_abort    (o_div_abort),
      .o_stall        (o_stall),
      .o_result       (o_result),
      .o_result_valid (o_result_valid),
      .o_busy         (o_busy)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      rv32_mulop   mulop;
      rv32_divop   divop;
      logic [31:0] a;
      logic [31:0] b;
      int          n;          // divider done index after start
      int          exp_stall;
      int          exp_en;
      int          exp_start;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] sb_q[$];
   logic        prev_valid = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mul_ref(input rv32_mulop op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] sa, sb, za, zb, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      za = {32'h0, a};
      zb = {32'h0, b};
      case (op)
         mulop_mulh:   p = sa * sb;
         mulop_mulhsu: p = sa * zb;
         mulop_mulhu:  p = za * zb;
         default:      p = {32'h0, za[31:0] * zb[31:0]};
      endcase
      return (op == mulop_mul) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [31:0] div_ref(input rv32_divop op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [31:0] r;
      if (b == 32'h0) return (op == divop_div || op == divop_divu) ? 32'hFFFF_FFFF : a;
      if ((op == divop_div || op == divop_rem) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return (op == divop_div) ? 32'h8000_0000 : 32'h0;
      case (op)
         divop_div:  r = $signed(a) / $signed(b);
         divop_rem:  r = $signed(a) % $signed(b);
         divop_divu: r = a / b;
         default:    r = a % b;
      endcase
      return r;
   endfunction

   // Scoreboard: each DONE entry must match the oldest committed expectation.
   always @(negedge i_clk) begin
      #2;
      if (i_rst) begin
         prev_valid = 1'b0;
      end else begin
         if (o_result_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_unexpected: result %h appeared with nothing expected", o_result);
            end else begin
               check("sb_result", o_result, sb_q.pop_front());
            end
         end
         prev_valid = o_result_valid;
      end
   end

   task automatic drive_idle();
      i_valid      = 1'b0;
      i_alu_en     = 1'b0;
      i_mulop      = mulop_none;
      i_divop      = divop_none;
      i_flush      = 1'b0;
      i_stall_down = 1'b0;
      i_div_done   = 1'b0;
      i_mul_result = 32'hDEAD_BEEF;
      i_div_result = 32'hBAD0_BAD0;
   endtask

   task automatic drive_op(input rv32_mulop mop, input rv32_divop dop,
                           input logic [31:0] a, input logic [31:0] b);
      i_valid  = 1'b1;
      i_alu_en = 1'b1;
      i_mulop  = mop;
      i_divop  = dop;
      i_data_a = a;
      i_data_b = b;
   endtask

   task automatic run_op(input vec_t v, input int hold, input string tag);
      int          stall_cnt = 0;
      int          en_cnt    = 0;
      int          start_cnt = 0;
      int          done_cyc  = 0;
      int          div_idx   = -1;
      int          cyc       = 0;
      bit          finished  = 1'b0;
      logic [31:0] exp_r;
      exp_r = (v.divop != divop_none) ? div_ref(v.divop, v.a, v.b)
                                      : mul_ref(v.mulop, v.a, v.b);
      @(negedge i_clk);
      drive_idle();
      drive_op(v.mulop, v.divop, v.a, v.b);
      i_stall_down = (hold > 0);
      sb_q.push_back(exp_r);
      while (!finished && cyc < 200) begin
         #1;
         if (o_stall) stall_cnt++;
         if (o_mul_en) en_cnt++;
         if (o_div_start) begin
            start_cnt++;
            div_idx = 0;
         end else if (div_idx >= 0) begin
            div_idx++;
         end
         i_mul_result = (o_mul_en && en_cnt == L) ? mul_ref(v.mulop, v.a, v.b) : 32'hDEAD_BEEF;
         i_div_done   = (div_idx == v.n);
         i_div_result = i_div_done ? div_ref(v.divop, v.a, v.b) : 32'hBAD0_BAD0;
         if (o_result_valid) begin
            check({tag, " held_result"}, o_result, exp_r);
            check({tag, " done_no_stall"}, o_stall, 1'b0);
            done_cyc++;
            if (done_cyc > hold) begin
               i_stall_down = 1'b0;
               finished     = 1'b1;
            end
         end
         @(negedge i_clk);
         cyc++;
      end
      drive_idle();
      check({tag, " timeout"}, finished, 1'b1);
      check({tag, " stall_cycles"}, stall_cnt, v.exp_stall);
      check({tag, " mul_en_cycles"}, en_cnt, v.exp_en);
      check({tag, " div_starts"}, start_cnt, v.exp_start);
      check({tag, " done_cycles"}, done_cyc, hold + 1);
      #1;
      check({tag, " back_to_idle"}, o_busy, 1'b0);
      check({tag, " idle_no_valid"}, o_result_valid, 1'b0);
   endtask

   // Divide that never completes on its own, flushed flush_at cycles after accept.
   task automatic flush_div(input int flush_at, input bit with_done, input string tag);
      @(negedge i_clk);
      drive_idle();
      drive_op(mulop_none, divop_divu, 32'd1000, 32'd3);
      repeat (flush_at) @(negedge i_clk);
      i_flush = 1'b1;
      if (with_done) begin
         i_div_done   = 1'b1;
         i_div_result = 32'd333;
      end
      #1;
      check({tag, " busy_before_flush"}, o_busy, 1'b1);
      check({tag, " abort"}, o_div_abort, !with_done);
      check({tag, " flush_no_stall"}, o_stall, 1'b0);
      @(negedge i_clk);
      drive_idle();
      #1;
      check({tag, " idle_after_flush"}, o_busy, 1'b0);
      check({tag, " no_valid_after_flush"}, o_result_valid, 1'b0);
   endtask

   vec_t vecs[13];
   vec_t hold_v;
   int   bad;

   initial begin
      vecs[0]  = '{mulop_mul,    divop_none, 32'd7,         32'd6,         0, 4,  3, 0};
      vecs[1]  = '{mulop_mulh,   divop_none, 32'hFFFF_FFFD, 32'd5,         0, 4,  3, 0};
      vecs[2]  = '{mulop_mulhsu, divop_none, 32'hFFFF_FFFF, 32'd2,         0, 4,  3, 0};
      vecs[3]  = '{mulop_mulhu,  divop_none, 32'hFFFF_FFFF, 32'd2,         0, 4,  3, 0};
      vecs[4]  = '{mulop_none,   divop_divu, 32'd100,       32'd7,         33, 35, 0, 1};
      vecs[5]  = '{mulop_none,   divop_div,  32'd5,         32'd0,         0, 1,  0, 0};
      vecs[6]  = '{mulop_none,   divop_rem,  32'h8000_0000, 32'hFFFF_FFFF, 0, 1,  0, 0};
      vecs[7]  = '{mulop_none,   divop_div,  32'h8000_0000, 32'hFFFF_FFFF, 0, 1,  0, 0};
      vecs[8]  = '{mulop_none,   divop_remu, 32'd9,         32'd0,         0, 1,  0, 0};
      vecs[9]  = '{mulop_none,   divop_rem,  32'hFFFF_FFF9, 32'd2,         0, 2,  0, 1};
      vecs[10] = '{mulop_none,   divop_div,  32'hFFFF_FFEC, 32'd3,         5, 7,  0, 1};
      vecs[11] = '{mulop_none,   divop_divu, 32'h8000_0000, 32'hFFFF_FFFF, 2, 4,  0, 1};
      vecs[12] = '{mulop_mul,    divop_divu, 32'd50,        32'd5,         1, 3,  0, 1};
      hold_v   = '{mulop_mul,    divop_none, 32'd12345,     32'd3,         0, 4,  3, 0};

      drive_idle();
      i_data_a = '0;
      i_data_b = '0;
      i_rst    = 1'b1;
      #1;
      check("reset_busy", o_busy, 1'b0);
      check("reset_stall", o_stall, 1'b0);
      check("reset_result", o_result, 32'h0);
      check("reset_outputs", {o_mul_en, o_div_start, o_div_abort, o_result_valid}, 4'h0);
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         run_op(vecs[i], 0, $sformatf("vec%0d", i));
      end

      run_op(hold_v, 4, "hold");

      flush_div(10, 1'b0, "flush_div");
      run_op(vecs[0], 0, "mul_after_flush");
      flush_div(4, 1'b1, "flush_with_done");

      // Reset lands off the clock edge while a divide is in flight.
      @(negedge i_clk);
      drive_idle();
      drive_op(mulop_none, divop_divu, 32'd1000, 32'd7);
      repeat (5) @(negedge i_clk);
      #1;
      check("pre_reset_busy", o_busy, 1'b1);
      #2;
      i_rst = 1'b1;
      #1;
      check("mid_reset_busy", o_busy, 1'b0);
      check("mid_reset_stall", o_stall, 1'b0);
      check("mid_reset_result", o_result, 32'h0);
      check("mid_reset_outputs", {o_mul_en, o_div_start, o_div_abort, o_result_valid}, 4'h0);
      @(negedge i_clk);
      i_rst = 1'b0;
      drive_op(mulop_none, divop_none, 32'd1, 32'd2);
      bad = 0;
      repeat (6) begin
         #1;
         if (o_stall || o_busy) bad++;
         @(negedge i_clk);
      end
      drive_idle();
      check("idle_instr_never_stalls", bad, 0);

      repeat (2) @(negedge i_clk);
      check("sb_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequences the shared multi-cycle multiply/divide resource that sits beside the execute-stage ALU.
- Detects M-extension ops leaving execute, drives the pipelined multiplier enable and the iterative divider start/abort handshake, and stalls the pipeline until the result is ready.
- Resolves divide-by-zero and signed overflow without using the divider.
- Holds the result for the ex-result mux until the pipeline advances.

Parameters:
- MUL_LATENCY, 3, cycles from mul enable to a valid i_mul_result (must be 1..15)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_flush  in  1  pipeline flush
- i_valid  in  1  execute-stage instruction valid
- i_alu_en  in  1  execute-stage ALU enable
- i_stall_down  in  1  stall request from stages after execute
- i_mulop  in  rv32_mulop  multiply op; mulop_none means no multiply
- i_divop  in  rv32_divop  divide op (divop_div/divu/rem/remu); divop_none means no divide
- i_data_a  in  32  dividend / multiplicand
- i_data_b  in  32  divisor / multiplier
- i_mul_result  in  32  multiplier output
- i_div_done  in  1  divider finished; result valid this cycle
- i_div_result  in  32  divider output (quotient or remainder per op)
- o_mul_en  out  1  multiplier advance enable
- o_div_start  out  1  one-cycle divider start pulse
- o_div_abort  out  1  cancel the divider in flight
- o_stall  out  1  hold the execute stage
- o_result  out  32  held M-extension result
- o_result_valid  out  1  o_result valid for the current execute instruction
- o_busy  out  1  state != IDLE

Behaviour:
- Reset (async, i_rst=1): state IDLE, counter 0, result register 0. All outputs 0.
- accept = state==IDLE && i_valid && i_alu_en && !i_flush && (i_mulop!=mulop_none || i_divop!=divop_none).
- If both ops are non-none, divide wins (decoder never emits this).
- IDLE on accept, with op and operands captured:
  - multiply: cnt <= MUL_LATENCY-1, go to MUL.
  - divide with i_data_b==0: go to DONE. Result is 32'hFFFFFFFF for div/divu, i_data_a for rem/remu.
  - divide with signed overflow (div/rem, a==32'h80000000, b==32'hFFFFFFFF): go to DONE. Result is 32'h80000000 for div, 0 for rem.
  - any other divide: go to DIV.
- MUL: o_mul_en=1. If cnt==0, capture i_mul_result and go to DONE; else cnt--.
- DIV:
  - o_div_start=1 only in the first DIV cycle (registered pulse).
  - i_div_done is sampled every DIV cycle. On done, capture i_div_result and go to DONE.
  - There is no timeout.
- DONE: o_result_valid=1.
  - Stay while i_stall_down=1.
  - Go to IDLE on the first cycle with i_stall_down=0. That cycle performs no accept, so the same instruction is never re-issued.
- o_stall = !i_flush && (accept || state==MUL || state==DIV). It is combinational, so the accept cycle already stalls.
  - Multiply stalls 1+MUL_LATENCY cycles.
  - Special-case divide stalls 1 cycle.
  - Normal divide stalls 2+N cycles, where N is the cycle index of i_div_done after start.
- Flush: from any state, go to IDLE next cycle and discard the captured result. Flush beats accept.
- o_div_abort = i_flush && state==DIV && !i_div_done.
- Simultaneous flush and i_div_done: result dropped, no abort.
- Reset mid-operation: immediate IDLE, outputs 0. The divider is reset separately by i_rst.
- o_result keeps its last value outside DONE. Consumers qualify it with o_result_valid.

Decomposition:
- The types package gains muldiv_state (IDLE, MUL, DIV, DONE) and constants DIV_BY_ZERO_Q=32'hFFFFFFFF and INT_MIN=32'h80000000.
- One combinational sub-module, div_special_case(i_divop, i_data_a, i_data_b → o_special, o_result). It is reused by the divider core's own checks.

Test Plan:
- mulop mul, a=7, b=6, MUL_LATENCY=3, i_mul_result=42 after 3 en cycles → o_stall high 4 cycles, o_mul_en high 3, then o_result_valid=1 and o_result=42 for 1 cycle.
- divu a=100, b=7, i_div_done 33 cycles after start with result 14 → exactly one o_div_start pulse, stall 35 cycles, o_result=14.
- div a=5, b=0 → no o_div_start, stall 1 cycle, o_result=32'hFFFFFFFF. rem a=32'h80000000, b=32'hFFFFFFFF → o_result=0.
- Divide in flight, i_flush at cycle 10 → o_div_abort=1 that cycle, state IDLE next, no o_result_valid. A following mul is accepted normally.
- Mul completes while i_stall_down=1 for 4 cycles → stays in DONE with o_result_valid=1 and stable o_result, o_stall=0, no re-accept. Returns to IDLE after release.
- Reset asserted mid-DIV (async, off clock edge) → all outputs 0 immediately. After release, an idle instruction with mulop_none/divop_none never asserts o_stall.
